s1s2_stream: RTL and testbench
==============================

S1S2_STREAM -- requirements
Module: s1s2_stream

Interface
REQ-001 SHALL have parameter m, default 67, field width in bits.
REQ-002 SHALL have parameter n, default 83, so that 2*n words are streamed.
REQ-003 SHALL have parameter DELAY_rd, default 2, cycles from S1S2_addr to valid S1S2_din (external address register plus BRAM register).
REQ-004 SHALL have parameter FIFO_DEPTH, default DELAY_rd+2, with FIFO_DEPTH >= DELAY_rd+1.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1, one-cycle request to stream the whole S1S2 memory.
REQ-008 SHALL have port busy, output, 1, high from the cycle after accepted start until finish.
REQ-009 SHALL have port finish, output, 1, one-cycle pulse after the last output beat.
REQ-010 SHALL have port S1S2_din, input, 2*m, read data from the S1S2 memory.
REQ-011 SHALL have port S1S2_addr, output, CLOG2(2*n), read address.
REQ-012 SHALL have port S1S2_rw, output, 1, tied 0 (read only).
REQ-013 SHALL have port out_valid, input ready out_ready, each 1 bit, forming the output handshake; a beat transfers when both are high at posedge.
REQ-014 SHALL have port out_s1, output, m, equal to S1S2_din[2m-1:m] of the word.
REQ-015 SHALL have port out_s2, output, m, equal to S1S2_din[m-1:0] of the word.
REQ-016 SHALL have port out_idx, output, CLOG2(2*n), source address of the current beat.
REQ-017 SHALL have port out_last, output, 1, high with out_valid on the beat where out_idx = 2n-1.

Function
REQ-018 SHALL implement FSM IDLE -> RUN (on start) -> DRAIN (last address issued) -> DONE (last beat accepted) -> IDLE (next cycle; finish=1 during DONE).
REQ-019 SHALL ignore start outside IDLE.
REQ-020 SHALL issue addresses 0,1,...,2n-1 in order, at most one per cycle, with no wrap and no repeat.
REQ-021 SHALL issue an address only when outstanding_reads + fifo_count < FIFO_DEPTH (credit check), so the FIFO never overflows.
REQ-022 SHALL track in-flight reads with a DELAY_rd-deep valid/address shift register, and push S1S2_din into the FIFO exactly DELAY_rd cycles after issue.
REQ-023 SHALL drive out_valid = FIFO non-empty, with out_s1/out_s2/out_idx/out_last taken from the FIFO head and stable while out_valid=1 and out_ready=0.
REQ-024 SHALL handle a simultaneous push and pop on a full or empty FIFO: the count is unchanged and data is not lost; an empty FIFO with a push presents the data next cycle (no bypass).
REQ-025 SHALL, with out_ready held at 1, sustain one beat per cycle; first out_valid appears DELAY_rd+1 cycles after start; total time from start to finish is 2n+DELAY_rd+2 cycles.
REQ-026 SHALL hold S1S2_addr at its last value when not issuing; the issue qualifier is internal.

Reset
REQ-027 SHALL, with rst=1 at posedge, enter IDLE, clear FIFO pointers and count, clear the in-flight shift register, and set busy=finish=out_valid=out_last=0 and S1S2_addr=0.
REQ-028 SHALL, when rst is asserted mid-stream, abort, emit no finish, and discard data returning from reads that were in flight.

Structure
REQ-029 SHALL place the CLOG2 macro and the state encodings in the shared header/package used by S1S2_gen.
REQ-030 SHALL implement the buffer as one sub-module, sync_fifo (WIDTH = 2*m + CLOG2(2*n) + 1, DEPTH = FIFO_DEPTH).

Verification
REQ-031 SHALL cover streaming with m=8, n=5, DELAY_rd=2, mem[k] = {k, ~k}, and out_ready=1: 10 beats with out_s1=k and out_s2=~k for k=0..9, out_last on k=9, and finish at cycle 14 after start.
REQ-032 SHALL cover out_ready=0 for 20 cycles after start: exactly FIFO_DEPTH=4 reads issued, out_idx=0 held stable, then the full ordered stream after release.
REQ-033 SHALL cover random out_ready (50%): all 10 beats in order with no duplicate or missing beat, and the FIFO never overflows.
REQ-034 SHALL cover rst pulsed at beat 4: outputs zero next cycle, no finish, and a subsequent start streams from idx 0.
REQ-035 SHALL cover start re-pulsed while busy: it is ignored, exactly 10 beats are produced, and exactly one finish pulse occurs.

Source files
------------

// File: rtl/s1s2_stream_pkg.sv
// Shared definitions for the S1S2 memory streamer: width helper macro and FSM state encoding.
`ifndef CLOG2
`define CLOG2(x) (((x) <= 2) ? 1 : $clog2(x))
`endif

package s1s2_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/s1s2_stream_if.sv
// Memory read bus plus the output beat handshake of the S1S2 streamer.
interface s1s2_stream_if #(
  parameter int m = 67,
  parameter int n = 83
);
  localparam int AW = `CLOG2(2*n);

  logic [2*m-1:0] S1S2_din;
  logic [AW-1:0]  S1S2_addr;
  logic           S1S2_rw;
  logic           out_valid;
  logic           out_ready;
  logic [m-1:0]   out_s1;
  logic [m-1:0]   out_s2;
  logic [AW-1:0]  out_idx;
  logic           out_last;

  modport master (
    input  S1S2_din, out_ready,
    output S1S2_addr, S1S2_rw, out_valid, out_s1, out_s2, out_idx, out_last
  );

  modport slave (
    output S1S2_din, out_ready,
    input  S1S2_addr, S1S2_rw, out_valid, out_s1, out_s2, out_idx, out_last
  );
endinterface

// File: rtl/s1s2_stream_sync_fifo.sv
// Synchronous FIFO (sync_fifo) with registered storage; a push into an empty FIFO is visible next cycle.
module s1s2_stream_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic                           empty_o,
  output logic [`CLOG2(DEPTH+1)-1:0]     count_o
);
  localparam int PW = `CLOG2(DEPTH);
  localparam int CW = `CLOG2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // A pop frees the head slot in the same edge, so a push on a full FIFO is still accepted.
  always_comb begin
    do_pop   = pop_i && (cnt_q != '0);
    do_push  = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/s1s2_stream.sv
// Streams all 2n words of the S1S2 memory out as {s1, s2, idx, last} beats under a credit-limited read pipeline.
module s1s2_stream
  import s1s2_stream_pkg::*;
#(
  parameter int m          = 67,
  parameter int n          = 83,
  parameter int DELAY_rd   = 2,
  parameter int FIFO_DEPTH = DELAY_rd + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          finish,
  s1s2_stream_if.master bus
);
  localparam int WORDS = 2 * n;
  localparam int AW    = `CLOG2(WORDS);
  localparam int FW    = 2 * m + AW + 1;
  localparam int CW    = `CLOG2(FIFO_DEPTH + 1);
  localparam int OW    = `CLOG2(DELAY_rd + 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            issue;

  logic [DELAY_rd-1:0] inf_vld_q;
  logic [AW-1:0]       inf_idx_q [DELAY_rd];
  logic [OW-1:0]       n_inflight;
  logic                credit_ok;

  logic            push, pop, fifo_empty;
  logic [FW-1:0]   push_data, head;
  logic [CW-1:0]   fifo_cnt;
  logic [m-1:0]    head_s1, head_s2;
  logic [AW-1:0]   head_idx;
  logic            head_last, out_valid;

  always_comb begin
    n_inflight = '0;
    for (int i = 0; i < DELAY_rd; i++) n_inflight = n_inflight + OW'(inf_vld_q[i]);
    credit_ok = (int'(n_inflight) + int'(fifo_cnt)) < FIFO_DEPTH;
  end

  // Control: FSM and address issue
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          issue   = 1'b1;
          addr_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (credit_ok) begin
          issue  = 1'b1;
          addr_d = addr_q + 1'b1;
          if (addr_q == AW'(WORDS - 2)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (pop && head_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy   = (state_q != ST_IDLE);
    finish = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      inf_vld_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      inf_vld_q[0] <= issue;
      for (int i = 1; i < DELAY_rd; i++) inf_vld_q[i] <= inf_vld_q[i-1];
    end
  end

  // Read latency tracking: the index rides alongside the valid bit
  always_ff @(posedge clk) begin
    inf_idx_q[0] <= addr_d;
    for (int i = 1; i < DELAY_rd; i++) inf_idx_q[i] <= inf_idx_q[i-1];
  end

  assign push      = inf_vld_q[DELAY_rd-1];
  assign push_data = {bus.S1S2_din, inf_idx_q[DELAY_rd-1], (inf_idx_q[DELAY_rd-1] == AW'(WORDS - 1))};

  s1s2_stream_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Output stage: fields from the FIFO head, forced to zero while no beat is offered
  assign head_s1   = head[FW-1 -: m];
  assign head_s2   = head[FW-m-1 -: m];
  assign head_idx  = head[AW:1];
  assign head_last = head[0];
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && bus.out_ready;

  assign bus.out_valid = out_valid;
  assign bus.out_s1    = out_valid ? head_s1  : '0;
  assign bus.out_s2    = out_valid ? head_s2  : '0;
  assign bus.out_idx   = out_valid ? head_idx : '0;
  assign bus.out_last  = out_valid && head_last;
  assign bus.S1S2_addr = addr_q;
  assign bus.S1S2_rw   = 1'b0;
endmodule

// File: tb/tb_s1s2_stream.sv
// Scoreboard bench for s1s2_stream: memory model {k, ~k}, queued expected beats, negedge monitor.
module tb_s1s2_stream;
  localparam int M     = 8;
  localparam int N     = 5;
  localparam int D     = 2;
  localparam int FD    = D + 2;
  localparam int WORDS = 2 * N;
  localparam int AW    = 4;

  typedef struct packed {
    logic [M-1:0]  s1;
    logic [M-1:0]  s2;
    logic [AW-1:0] idx;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, finish;

  s1s2_stream_if #(.m(M), .n(N)) bus ();

  s1s2_stream #(.m(M), .n(N), .DELAY_rd(D), .FIFO_DEPTH(FD)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .busy   (busy),
    .finish (finish),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Memory: one register after the external address register, so data follows the address by D edges.
  logic [2*M-1:0] rd_q;
  always @(posedge clk) rd_q <= {M'(bus.S1S2_addr), ~(M'(bus.S1S2_addr))};
  assign bus.S1S2_din = rd_q;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    t0 = 0;
  int    beats, fin_cnt, first_rel, fin_rel;
  int    ready_mode = 0;
  int    hold_until = 20;
  bit    credit_bad;
  logic  busy_at1;
  logic  busy_prev = 1'b0;
  logic [AW-1:0] addr_prev = '0;
  beat_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = ((cyc - t0) >= hold_until);
      endcase
    end
  end

  // Monitor: compare every offered beat with the scoreboard head; pop on transfer.
  always @(negedge clk) begin
    int    rel;
    beat_t e;
    if (rst !== 1'b1) begin
      rel = cyc - t0 + 1;
      if (rel == 1) busy_at1 = busy;
      if (busy === 1'b1) begin
        if ((int'(bus.S1S2_addr) + 1 - beats) > FD) credit_bad = 1'b1;
        if (busy_prev && bus.S1S2_addr != addr_prev && bus.S1S2_addr != addr_prev + 4'd1) credit_bad = 1'b1;
        if (int'(bus.S1S2_addr) >= WORDS) credit_bad = 1'b1;
      end
      if (bus.out_valid === 1'b1) begin
        if (first_rel < 0) first_rel = rel;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got idx %0d, expected no beat", bus.out_idx);
        end else begin
          e = exp_q[0];
          chk("beat_s1",   32'(bus.out_s1),   32'(e.s1));
          chk("beat_s2",   32'(bus.out_s2),   32'(e.s2));
          chk("beat_idx",  32'(bus.out_idx),  32'(e.idx));
          chk("beat_last", 32'(bus.out_last), 32'(e.last));
          if (bus.out_ready === 1'b1) begin
            void'(exp_q.pop_front());
            beats++;
          end
        end
      end
      if (finish === 1'b1) begin
        fin_cnt++;
        fin_rel = rel;
      end
      busy_prev = busy;
      addr_prev = bus.S1S2_addr;
    end else begin
      busy_prev = 1'b0;
    end
  end

  task automatic load_expected();
    for (int k = 0; k < WORDS; k++)
      exp_q.push_back('{s1: M'(k), s2: ~(M'(k)), idx: AW'(k), last: (k == WORDS - 1)});
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    t0    = cyc + 1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_stream(input int mode, input int repulse_at, input bit check_timing);
    int waited;
    ready_mode = mode;
    beats      = 0;
    fin_cnt    = 0;
    first_rel  = -1;
    fin_rel    = -1;
    credit_bad = 1'b0;
    busy_at1   = 1'b0;
    load_expected();
    pulse_start();
    if (mode == 2) begin
      repeat (20) @(negedge clk);
      chk("hold_reads_issued", 32'(bus.S1S2_addr), 32'(FD - 1));
      chk("hold_idx",          32'(bus.out_idx),   32'd0);
      chk("hold_valid",        32'(bus.out_valid), 32'd1);
    end
    if (repulse_at > 0) begin
      repeat (repulse_at) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    waited = 0;
    while (fin_cnt == 0 && waited < 300) begin
      @(posedge clk);
      waited++;
    end
    chk("stream_finished", 32'(fin_cnt != 0), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("beat_count",    32'(beats),         32'(WORDS));
    chk("finish_pulses", 32'(fin_cnt),       32'd1);
    chk("queue_empty",   32'(exp_q.size()),  32'd0);
    chk("credit_order",  32'(credit_bad),    32'd0);
    chk("last_addr",     32'(bus.S1S2_addr), 32'(WORDS - 1));
    chk("busy_after",    32'(busy),          32'd0);
    if (check_timing) begin
      chk("busy_cycle1",            32'(busy_at1),    32'd1);
      chk("first_valid_cycle",      32'(first_rel),   32'(D + 1));
      chk("start_to_finish_cycles", 32'(fin_rel + 1), 32'(2 * N + D + 2));
    end
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   32'(busy),          32'd0);
    chk("rst_finish", 32'(finish),        32'd0);
    chk("rst_valid",  32'(bus.out_valid), 32'd0);
    chk("rst_last",   32'(bus.out_last),  32'd0);
    chk("rst_addr",   32'(bus.S1S2_addr), 32'd0);
    chk("rst_rw",     32'(bus.S1S2_rw),   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_stream(0, 0, 1'b1);
    run_stream(2, 0, 1'b0);
    run_stream(1, 0, 1'b0);
    run_stream(1, 0, 1'b0);

    // Abort after the fourth beat.
    ready_mode = 0;
    beats      = 0;
    fin_cnt    = 0;
    first_rel  = -1;
    credit_bad = 1'b0;
    load_expected();
    pulse_start();
    waited = 0;
    while (beats < 4 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    chk("abort_reached_beat4", 32'(beats >= 4), 32'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_valid",  32'(bus.out_valid), 32'd0);
    chk("abort_last",   32'(bus.out_last),  32'd0);
    chk("abort_s1",     32'(bus.out_s1),    32'd0);
    chk("abort_s2",     32'(bus.out_s2),    32'd0);
    chk("abort_idx",    32'(bus.out_idx),   32'd0);
    chk("abort_busy",   32'(busy),          32'd0);
    chk("abort_finish", 32'(finish),        32'd0);
    chk("abort_addr",   32'(bus.S1S2_addr), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_finish", 32'(fin_cnt),       32'd0);
    chk("abort_idle",      32'(bus.out_valid), 32'd0);
    run_stream(0, 0, 1'b1);

    run_stream(0, 5, 1'b0);
    run_stream(1, 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
